aes_round_datapath: RTL and testbench
=====================================

Name: aes_round_datapath

Overview:
- Registered single-round AES-128 encryption datapath. Per operation it applies SubBytes (16 parallel S-box lookups), then ShiftRows, then MixColumns (skipped on the final round), then AddRoundKey.
- Sits between the round controller and the state register of the AES core.
- The controller supplies the state, the round key and a final-round flag.
- The block returns the next round state one clock later.

Parameters:
- None. Widths are fixed by AES-128: 128-bit state, 8-bit bytes.

Ports:
- clock  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  capture request; inputs are sampled on the same edge
- state_in  input  128  round input state
- round_key  input  128  round key applied by AddRoundKey
- final_round  input  1  1 = bypass MixColumns (AES round 10)
- out_valid  output  1  registered; high for exactly one cycle per accepted request
- state_out  output  128  registered round output state

Behaviour:
- Byte packing: state byte i (i = 0..15) occupies bits [8i+7:8i]. Byte i is row r = i mod 4, column c = i div 4 (FIPS-197 column-major order). round_key uses the same packing.
- SubBytes: each byte is replaced by the FIPS-197 AES forward S-box value. Either a 256-entry constant table or GF(2^8) inversion plus affine transform is acceptable; results must be bit-exact.
  - Anchor values: S(00)=63, S(01)=7c, S(53)=ed, S(ff)=16.
- ShiftRows: out[r][c] = in[r][(c+r) mod 4].
  - Row 0 is unchanged.
  - Row 1 rotates left by 1, row 2 by 2, row 3 by 3.
- MixColumns, per column (a0..a3 = rows 0..3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - Arithmetic is in GF(2^8) with modulus x^8+x^4+x^3+x+1.
  - xtime(a) = (a<<1) ^ (a[7] ? 8'h1b : 0).
- Final round: when final_round=1, the MixColumns output equals its input, i.e. the bypass is applied to the ShiftRows result.
- AddRoundKey: result = (MixColumns or bypass output) XOR round_key.
- The whole transform is combinational; only the output is registered. The combinational path feeds the state_out register.
- On a rising edge with in_valid=1:
  - state_out <= result.
  - out_valid <= 1.
  - Latency is exactly 1 clock.
- On a rising edge with in_valid=0:
  - state_out holds its value.
  - out_valid <= 0.
- Throughput: one request per clock. Back-to-back in_valid cycles each produce an output on the following cycle. There is no backpressure and no ready signal.
- Reset:
  - resetn=0 asynchronously forces state_out = 128'h0 and out_valid = 0, independent of the clock.
  - An operation in flight when reset asserts is discarded.
  - The first capture after release happens on the first rising edge with resetn=1 and in_valid=1.
- final_round and round_key are sampled only on edges where in_valid=1. Their values in other cycles have no effect.
- No X propagation from unused inputs: the output register is loaded only when in_valid=1.

Test Plan:
- Reset: assert resetn=0 mid-operation with in_valid=1 -> state_out=0 and out_valid=0 immediately. After release with in_valid=0, both stay 0.
- All-zero state, zero key, final_round=1 -> one cycle later state_out = all bytes 63 and out_valid=1. The same input with final_round=0 also gives all bytes 63.
- FIPS-197 round 1, final_round=0:
  - state_in bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08
  - round_key bytes = a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05
  - Expected state_out bytes = a4 9c 7f f2 68 9f 35 2b 6b 5b ea 43 02 6a 50 49
- MixColumns check via a chosen state:
  - Column 0 pre-image chosen so that after SubBytes/ShiftRows it is db 13 53 45, with round_key=0 and final_round=0.
  - Expected column 0 output = 8e 4d a1 bc.
  - With final_round=1, expected column 0 output = db 13 53 45 unchanged.
- Back-to-back: three consecutive in_valid cycles with distinct states -> three consecutive out_valid pulses, each carrying its matching result. Then in_valid=0 -> out_valid=0 and state_out holds the last result.
- S-box sweep: for each byte value v, state_in = 16 copies of v, key 0, final_round=1 -> every output byte equals S(v) for all 256 values, checked against the FIPS-197 table.

Source files
------------

// File: rtl/aes_round_datapath.sv
// ---------------------------------------------------------------------------
// Module   : aes_round_datapath
// Purpose  : One registered AES-128 encryption round
//            (SubBytes, ShiftRows, MixColumns/bypass, AddRoundKey).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module aes_round_datapath (
  input  logic         clock,
  input  logic         resetn,
  input  logic         in_valid,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic         out_valid,
  output logic [127:0] state_out
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] v);
    // ~v == 255 - v, so this selects entry v counted from the top.
    return c_SBOX[{~v, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0]   w_sub [16];
  logic [7:0]   w_sr  [16];
  logic [7:0]   w_mix [16];
  logic [127:0] w_result;

  logic         out_valid_q, out_valid_d;
  logic [127:0] state_out_q, state_out_d;

  genvar gi, gr, gc;

  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub
      assign w_sub[gi] = sbox(state_in[8*gi +: 8]);
    end

    for (gc = 0; gc < 4; gc++) begin : g_sr_col
      for (gr = 0; gr < 4; gr++) begin : g_sr_row
        assign w_sr[gr + 4*gc] = w_sub[gr + 4*((gc + gr) % 4)];
      end
    end

    for (gc = 0; gc < 4; gc++) begin : g_mix
      logic [7:0] w_a0, w_a1, w_a2, w_a3;
      assign w_a0 = w_sr[4*gc + 0];
      assign w_a1 = w_sr[4*gc + 1];
      assign w_a2 = w_sr[4*gc + 2];
      assign w_a3 = w_sr[4*gc + 3];
      // 3a is written as xtime(a) ^ a.
      assign w_mix[4*gc + 0] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
      assign w_mix[4*gc + 1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
      assign w_mix[4*gc + 2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
      assign w_mix[4*gc + 3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end

    for (gi = 0; gi < 16; gi++) begin : g_ark
      assign w_result[8*gi +: 8] = (final_round ? w_sr[gi] : w_mix[gi])
                                   ^ round_key[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_out_d = state_out_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      state_out_d = w_result;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      state_out_q <= 128'h0;
    end else begin
      out_valid_q <= out_valid_d;
      state_out_q <= state_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign state_out = state_out_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_datapath.sv
// ---------------------------------------------------------------------------
// Module   : tb_aes_round_datapath
// Purpose  : Self-checking bench for aes_round_datapath.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aes_round_datapath;

  logic         clock = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         final_round;
  logic         out_valid;
  logic [127:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  aes_round_datapath dut (
    .clock       (clock),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .state_in    (state_in),
    .round_key   (round_key),
    .final_round (final_round),
    .out_valid   (out_valid),
    .state_out   (state_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    string        name;
    logic [127:0] st;
    logic [127:0] key;
    logic         fin;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [6];

  // Literals are written byte 0 first; reverse into bit packing.
  function automatic logic [127:0] pk(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Reference S-box from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] v);
    logic [7:0] inv = 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (v != 8'h00 && gmul(v, 8'(b)) == 8'h01) inv = 8'(b);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [127:0] st, input logic [127:0] key, input logic fin);
    in_valid    = 1'b1;
    state_in    = st;
    round_key   = key;
    final_round = fin;
  endtask

  task automatic single(input logic [127:0] st, input logic [127:0] key, input logic fin);
    drive(st, key, fin);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  logic [127:0] mc_state;
  logic [7:0]   sv;

  initial begin
    mc_state = pk(128'h9f000000_00820000_00005000_00000068);

    tbl[0] = '{"zero_fin1", 128'h0, 128'h0, 1'b1, {16{8'h63}}};
    tbl[1] = '{"zero_fin0", 128'h0, 128'h0, 1'b0, {16{8'h63}}};
    tbl[2] = '{"fips_round1",
               pk(128'h193de3be_a0f4e22b_9ac68d2a_e9f84808),
               pk(128'ha0fafe17_88542cb1_23a33939_2a6c7605), 1'b0,
               pk(128'ha49c7ff2_689f352b_6b5bea43_026a5049)};
    tbl[3] = '{"mixcol_fin0", mc_state, 128'h0, 1'b0,
               pk(128'h8e4da1bc_63636363_63636363_63636363)};
    tbl[4] = '{"mixcol_fin1", mc_state, 128'h0, 1'b1,
               pk(128'hdb135345_63636363_63636363_63636363)};
    tbl[5] = '{"zero_key_fin1", 128'h0,
               pk(128'h00010203_04050607_08090a0b_0c0d0e0f), 1'b1,
               pk(128'h63626160_67666564_6b6a6968_6f6e6d6c)};

    resetn = 1'b0; in_valid = 1'b0;
    state_in = '0; round_key = '0; final_round = 1'b0;
    #1;
    check("reset_state_out", state_out, 128'h0);
    check("reset_out_valid", {127'h0, out_valid}, 128'h0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      single(tbl[i].st, tbl[i].key, tbl[i].fin);
      check({tbl[i].name, "_data"}, state_out, tbl[i].exp);
      check({tbl[i].name, "_valid"}, {127'h0, out_valid}, 128'h1);
      @(negedge clock);
      check({tbl[i].name, "_valid_drop"}, {127'h0, out_valid}, 128'h0);
    end

    // Back-to-back requests, then idle hold with noisy ignored inputs.
    drive(tbl[2].st, tbl[2].key, tbl[2].fin);
    @(negedge clock);
    check("b2b_0_valid", {127'h0, out_valid}, 128'h1);
    check("b2b_0_data", state_out, tbl[2].exp);
    drive(tbl[3].st, tbl[3].key, tbl[3].fin);
    @(negedge clock);
    check("b2b_1_valid", {127'h0, out_valid}, 128'h1);
    check("b2b_1_data", state_out, tbl[3].exp);
    drive(tbl[5].st, tbl[5].key, tbl[5].fin);
    @(negedge clock);
    check("b2b_2_valid", {127'h0, out_valid}, 128'h1);
    check("b2b_2_data", state_out, tbl[5].exp);
    in_valid = 1'b0;
    state_in = {4{$urandom}}; round_key = {4{$urandom}}; final_round = 1'b0;
    @(negedge clock);
    check("idle_valid", {127'h0, out_valid}, 128'h0);
    check("idle_hold", state_out, tbl[5].exp);
    final_round = 1'b1; round_key = ~round_key;
    @(negedge clock);
    check("idle_hold2", state_out, tbl[5].exp);

    // Asynchronous reset in the middle of a cycle with a request pending.
    drive(tbl[2].st, tbl[2].key, tbl[2].fin);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_data", state_out, 128'h0);
    check("async_rst_valid", {127'h0, out_valid}, 128'h0);
    @(negedge clock);
    in_valid = 1'b0;
    resetn   = 1'b1;
    @(negedge clock);
    check("post_rst_data", state_out, 128'h0);
    check("post_rst_valid", {127'h0, out_valid}, 128'h0);
    single(tbl[0].st, tbl[0].key, tbl[0].fin);
    check("first_after_rst", state_out, tbl[0].exp);

    // S-box sweep: replicate each value over all bytes, bypass MixColumns.
    for (int v = 0; v < 256; v++) begin
      sv = 8'(v);
      single({16{sv}}, 128'h0, 1'b1);
      check($sformatf("sbox_%02h", sv), state_out, {16{sbox_ref(sv)}});
      if (sv == 8'h00) check("anchor_00", state_out, {16{8'h63}});
      if (sv == 8'h01) check("anchor_01", state_out, {16{8'h7c}});
      if (sv == 8'h53) check("anchor_53", state_out, {16{8'hed}});
      if (sv == 8'hff) check("anchor_ff", state_out, {16{8'h16}});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
